line_raster_engine: RTL
=======================

// Module: line_raster_engine
// PURPOSE
//  Parametrised Bresenham line rasteriser, all eight octants, one pixel per accepted handshake.
//  Accepts endpoint pairs from the triangle/wireframe front end and streams (x,y,colour) to the framebuffer writer.
//  Adds over the fixed 10-bit drawer: generic coordinate width, valid/ready backpressure, dash-pattern mode, abort.
// PARAMETERS
//  COORD_W    10     unsigned coordinate width (x and y)
//  COLOR_W    8      colour word width, passed through unchanged
//  PATTERN_W  8      dash-pattern length in pixels
// PORTS
//  Clk         in   1          system clock, all logic on rising edge
//  Reset       in   1          synchronous, active-low reset
//  start       in   1          request new line; accepted only in IDLE
//  abort       in   1          cancel current line; no done pulse
//  x0,y0       in   COORD_W    start point, sampled on accepted start
//  x1,y1       in   COORD_W    end point, sampled on accepted start
//  color       in   COLOR_W    line colour, sampled on accepted start
//  pattern     in   PATTERN_W  dash mask (bit i = draw pixel i mod PATTERN_W); all-ones = solid
//  busy        out  1          high from accepted start until done/abort
//  pix_valid   out  1          pix_x/pix_y/pix_color valid
//  pix_ready   in   1          consumer accepts pixel when pix_valid & pix_ready
//  pix_x,pix_y out  COORD_W    pixel coordinate
//  pix_color   out  COLOR_W    pixel colour
//  pix_last    out  1          qualifies pix_valid: this pixel is the endpoint (x1,y1)
//  done        out  1          one-cycle pulse after the last pixel step
// BEHAVIOUR
//  Reset low: state=IDLE; busy, pix_valid, pix_last, done = 0; pix_x, pix_y, pix_color = 0.
//  FSM IDLE -> SETUP -> RUN -> DONE -> IDLE. start ignored outside IDLE.
//  SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 by sign, err=dx+dy;
//   dx/dy/err are signed COORD_W+2 bits (no overflow for any endpoint pair). Pattern index=0.
//  Latency: start accepted cycle N -> first pix_valid in cycle N+2 (solid pattern).
//  RUN, each step: if pattern[idx]: hold pix_valid until pix_ready; x,y,colour stable while stalled.
//   If pattern[idx]=0: pixel skipped, step taken next cycle with no handshake.
//   Step: if (x,y)==(x1,y1) -> DONE; else e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy};
//   both updates apply in the same cycle on diagonals; idx wraps PATTERN_W-1 -> 0.
//  Pixel steps per line = max(dx,|dy|)+1, including both endpoints; never overruns x1/y1.
//  Coordinates never wrap: end test uses equality, so x/y stay between endpoints.
//  Degenerate x0==x1 & y0==y1: exactly one step, pix_last=1 if pattern[0]=1.
//  pix_last asserted only with an emitted endpoint; masked endpoint -> no pix_last, done still pulses.
//  DONE: done=1 for one cycle, busy drops same cycle, back to IDLE; new start accepted next cycle.
//  abort (any state except IDLE): next cycle IDLE, pix_valid=0, busy=0, done not pulsed.
//   abort beats pix_ready in the same cycle: that pixel counts as not transferred.
//  Reset low mid-line: same as reset values, line discarded.
//  start and abort together in IDLE: start accepted (abort has no effect in IDLE).
// STRUCTURE
//  Package line_raster_pkg: state enum {IDLE,SETUP,RUN,DONE}; coord_t/err_t typedefs sized from COORD_W.
//  Sub-module line_step (combinational): err,x,y,dx,dy,sx,sy -> next err,x,y, at_end.
//  Top holds FSM, endpoint/colour/pattern registers, handshake and pattern index.
// TESTING
//  Solid (20,20)->(40,20), pix_ready=1: 21 pixels, x=20..40, y=20, pix_last on x=40, done 1 cycle later.
//  Steep reversed (30,40)->(27,30): 11 pixels, y=40..30, x monotonically 30->27, last (27,30).
//  Single point (5,5)->(5,5): one pixel (5,5) with pix_last, then done; busy high 3 cycles.
//  Backpressure: (0,0)->(7,7), pix_ready random 50%: exactly 8 unique diagonal pixels, no drop/duplicate.
//  Dash pattern 8'b0000_0011, PATTERN_W=8, (0,0)->(9,0): emitted x=0,1,8,9; pix_last on x=9; done.
//  Abort at 5th pixel of (0,0)->(100,0), then Reset low mid-line on another: no done; next line (3,3)->(4,3) OK.

Source files
------------

// File: rtl/line_raster_engine_pkg.sv
// rtl/line_raster_engine_pkg.sv - shared types and helpers for the line rasteriser
package line_raster_pkg;

  localparam int DEF_COORD_W   = 10;
  localparam int DEF_COLOR_W   = 8;
  localparam int DEF_PATTERN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } state_t;

  // Default-width views of a coordinate and of the signed error term (two guard bits)
  typedef logic [DEF_COORD_W-1:0]        coord_t;
  typedef logic signed [DEF_COORD_W+1:0] err_t;

  // Width of the dash-pattern index; never zero so a 1-pixel pattern still has a register
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_raster_engine_if.sv
// rtl/line_raster_engine_if.sv - command and pixel-stream bundle for the line rasteriser
interface line_raster_engine_if #(
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 8,
  parameter int PATTERN_W = 8
);

  logic                 start;
  logic                 abort;
  logic [COORD_W-1:0]   x0;
  logic [COORD_W-1:0]   y0;
  logic [COORD_W-1:0]   x1;
  logic [COORD_W-1:0]   y1;
  logic [COLOR_W-1:0]   color;
  logic [PATTERN_W-1:0] pattern;
  logic                 busy;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [COORD_W-1:0]   pix_x;
  logic [COORD_W-1:0]   pix_y;
  logic [COLOR_W-1:0]   pix_color;
  logic                 pix_last;
  logic                 done;

  modport master (
    output start, abort, x0, y0, x1, y1, color, pattern, pix_ready,
    input  busy, pix_valid, pix_x, pix_y, pix_color, pix_last, done
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, color, pattern, pix_ready,
    output busy, pix_valid, pix_x, pix_y, pix_color, pix_last, done
  );

endinterface

// File: rtl/line_raster_engine_step.sv
// rtl/line_raster_engine_step.sv - one combinational Bresenham step and endpoint test
module line_step #(
  parameter int COORD_W = 10
) (
  input  logic signed [COORD_W+1:0] err,
  input  logic signed [COORD_W+1:0] dx,
  input  logic signed [COORD_W+1:0] dy,
  input  logic        [COORD_W-1:0] x,
  input  logic        [COORD_W-1:0] y,
  input  logic        [COORD_W-1:0] x_end,
  input  logic        [COORD_W-1:0] y_end,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  output logic signed [COORD_W+1:0] err_next,
  output logic        [COORD_W-1:0] x_next,
  output logic        [COORD_W-1:0] y_next,
  output logic                      at_end
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  // e2 = 2*err needs one more bit than err; dx/dy are sign-extended to match
  logic signed [COORD_W+2:0] e2;
  logic signed [COORD_W+2:0] dx_w;
  logic signed [COORD_W+2:0] dy_w;

  assign e2     = {err, 1'b0};
  assign dx_w   = {dx[COORD_W+1], dx};
  assign dy_w   = {dy[COORD_W+1], dy};
  assign at_end = (x == x_end) && (y == y_end);

  // Both axis moves may fire together, which produces the diagonal steps
  always_comb begin
    err_next = err;
    x_next   = x;
    y_next   = y;
    if (e2 >= dy_w) begin
      err_next = err_next + dy;
      x_next   = sx_neg ? (x - ONE) : (x + ONE);
    end
    if (e2 <= dx_w) begin
      err_next = err_next + dx;
      y_next   = sy_neg ? (y - ONE) : (y + ONE);
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// rtl/line_raster_engine.sv - Bresenham line rasteriser with backpressure, dash pattern and abort
module line_raster_engine
  import line_raster_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int PATTERN_W = DEF_PATTERN_W
) (
  input logic                 Clk,
  input logic                 Reset,
  line_raster_engine_if.slave bus
);

  localparam int ERR_W = COORD_W + 2;
  localparam int IDX_W = idx_width(PATTERN_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t state, state_next;

  logic [COORD_W-1:0]      cur_x, cur_y, end_x, end_y;
  logic [COORD_W-1:0]      x_next, y_next;
  logic [COORD_W-1:0]      dx_abs, dy_abs;
  logic [COLOR_W-1:0]      color_r;
  logic [PATTERN_W-1:0]    pattern_r;
  logic signed [ERR_W-1:0] dx_r, dy_r, err_r, err_next;
  logic                    sx_neg, sy_neg;
  logic [IDX_W-1:0]        idx_r;
  logic                    at_end;
  logic                    draw_bit;
  logic                    accept, step;
  logic                    busy_c, done_c, pix_valid_c;

  // At SETUP cur_x/cur_y still hold the start point, so the deltas come straight from the registers
  assign dx_abs   = (end_x >= cur_x) ? (end_x - cur_x) : (cur_x - end_x);
  assign dy_abs   = (end_y >= cur_y) ? (end_y - cur_y) : (cur_y - end_y);
  assign draw_bit = pattern_r[idx_r];

  line_step #(
    .COORD_W (COORD_W)
  ) u_step (
    .err      (err_r),
    .dx       (dx_r),
    .dy       (dy_r),
    .x        (cur_x),
    .y        (cur_y),
    .x_end    (end_x),
    .y_end    (end_y),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .err_next (err_next),
    .x_next   (x_next),
    .y_next   (y_next),
    .at_end   (at_end)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake decode; abort masks pix_valid so an aborted pixel never transfers
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    step        = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    pix_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          busy_c     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        busy_c     = 1'b1;
        state_next = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        busy_c      = 1'b1;
        pix_valid_c = draw_bit && !bus.abort;
        if (bus.abort) begin
          state_next = IDLE;
        end else if (!draw_bit || bus.pix_ready) begin
          step = 1'b1;
          if (at_end) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done_c     = !bus.abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line context: captured on accept, deltas set up once, then walked one step per advance
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cur_x     <= '0;
      cur_y     <= '0;
      end_x     <= '0;
      end_y     <= '0;
      color_r   <= '0;
      pattern_r <= '0;
      dx_r      <= '0;
      dy_r      <= '0;
      err_r     <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      idx_r     <= '0;
    end else begin
      if (accept) begin
        cur_x     <= bus.x0;
        cur_y     <= bus.y0;
        end_x     <= bus.x1;
        end_y     <= bus.y1;
        color_r   <= bus.color;
        pattern_r <= bus.pattern;
      end
      if (state == SETUP) begin
        dx_r   <= $signed({2'b00, dx_abs});
        dy_r   <= -$signed({2'b00, dy_abs});
        err_r  <= $signed({2'b00, dx_abs}) - $signed({2'b00, dy_abs});
        sx_neg <= (end_x < cur_x);
        sy_neg <= (end_y < cur_y);
        idx_r  <= '0;
      end
      if (step && !at_end) begin
        cur_x <= x_next;
        cur_y <= y_next;
        err_r <= err_next;
        idx_r <= (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_ONE);
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.pix_valid = pix_valid_c;
  assign bus.pix_last  = pix_valid_c && at_end;
  assign bus.pix_x     = cur_x;
  assign bus.pix_y     = cur_y;
  assign bus.pix_color = color_r;

endmodule
